jt12_chacc: RTL and testbench

//  Consumes the serial 9-bit operator stream from the operator pipeline (24 slots/frame).

---
 rtl/jt12_chacc_pkg.sv | 30 +++
 rtl/jt12_sh.sv | 23 ++
 rtl/jt12_chacc.sv | 126 ++++++++++++
 tb/tb_jt12_chacc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jt12_chacc_pkg.sv
// Shared types and constants for the jt12 channel accumulator.
// Algorithm carrier table, channel saturation limits and datapath widths.
package jt12_chacc_pkg;

  typedef logic signed [8:0]  op_t;
  typedef logic signed [10:0] chsum_t;
  typedef logic signed [11:0] mix_t;

  typedef enum logic { UNARMED = 1'b0, ARMED = 1'b1 } arm_t;

  // Encoding doubles as the bit index into the carrier mask {S4,S3,S2,S1}
  typedef enum logic [1:0] { GRP_S1 = 2'd0, GRP_S2 = 2'd1, GRP_S3 = 2'd2, GRP_S4 = 2'd3 } grp_t;

  localparam int CH_MAX = 255;
  localparam int CH_MIN = -256;

  localparam logic [7:0][3:0] ALG_MASK = {
    4'b1111,                            // alg 7
    4'b1110, 4'b1110,                   // alg 6, 5
    4'b1010,                            // alg 4
    4'b1000, 4'b1000, 4'b1000, 4'b1000  // alg 3..0
  };

  function automatic logic is_carrier(input logic [2:0] a, input grp_t g);
    logic [3:0] m;
    m = ALG_MASK[a];
    return m[g];
  endfunction

endpackage

// File: rtl/jt12_sh.sv
// Plain clock-enabled shift register; contents need no reset.
module jt12_sh #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 6
) (
  input  logic             clk,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] drop
);

  logic [WIDTH-1:0] bits [STAGES];

  always_ff @(posedge clk) begin
    if (clk_en) begin
      bits[0] <= din;
      for (int i = 1; i < STAGES; i++) bits[i] <= bits[i-1];
    end
  end

  assign drop = bits[STAGES-1];

endmodule

// File: rtl/jt12_chacc.sv
// Channel accumulator: sums carrier operators per channel, saturates, pans and mixes.
// Optional PCM replacement of channel 5 is enabled by defining JT12_CHACC_PCM_EN.
module jt12_chacc
  import jt12_chacc_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 9,
  parameter int MIX_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [CH_W-1:0]  op_result,
  input  logic                    s1_enters,
  input  logic                    s2_enters,
  input  logic                    s3_enters,
  input  logic                    s4_enters,
  input  logic [2:0]              alg,
  input  logic [1:0]              rl,
`ifdef JT12_CHACC_PCM_EN
  input  logic signed [CH_W-1:0]  pcm,
  input  logic                    pcm_en,
`endif
  output logic signed [MIX_W-1:0] left,
  output logic signed [MIX_W-1:0] right,
  output logic                    sample_valid
);

  localparam logic [2:0] CNT_MAX  = 3'(NUM_CH);
  localparam logic [2:0] CNT_LAST = 3'(NUM_CH - 1);

  function automatic op_t sat(input chsum_t v);
    if (v > chsum_t'(CH_MAX))      return op_t'(CH_MAX);
    else if (v < chsum_t'(CH_MIN)) return op_t'(CH_MIN);
    else                           return op_t'(v);
  endfunction

  arm_t       state;
  logic [2:0] cnt;
  logic       vld_p1;
  mix_t       mix_l_p1, mix_r_p1;

  grp_t       grp;
  logic       grp_vld;
  chsum_t     c, sum_in, sum_next;
  logic [10:0] sh_din, sh_drop;
  op_t        ch;
  logic       s3_take;

  // Stage 0: slot decode, carrier select, running sum and channel saturation
  always_comb begin
    grp_vld = 1'b1;
    grp     = GRP_S4;
    if (s1_enters)      grp = GRP_S2;
    else if (s2_enters) grp = GRP_S1;
    else if (s3_enters) grp = GRP_S4;
    else if (s4_enters) grp = GRP_S3;
    else                grp_vld = 1'b0;
  end

  assign sum_in   = sh_drop;
  assign c        = (grp_vld && is_carrier(alg, grp)) ? chsum_t'(op_result) : '0;
  assign sum_next = sum_in + c;

  always_comb begin
    sh_din = sum_in;
    if (grp_vld) begin
      case (grp)
        GRP_S2:         sh_din = c;
        GRP_S4, GRP_S1: sh_din = sum_next;
        default:        sh_din = sum_in;
      endcase
    end
  end

  always_comb begin
    ch = sat(sum_next);
`ifdef JT12_CHACC_PCM_EN
    if (pcm_en && cnt == CNT_LAST) ch = pcm;
`endif
  end

  assign s3_take = grp_vld && (grp == GRP_S3) && (state == ARMED) && (cnt < CNT_MAX);

  jt12_sh #(.WIDTH(11), .STAGES(NUM_CH)) u_sh (
    .clk    (clk),
    .clk_en (clk_en),
    .din    (sh_din),
    .drop   (sh_drop)
  );

  // Stage 1: per-frame mix accumulation (first S3 slot loads)
  always_ff @(posedge clk) begin
    if (clk_en && s3_take) begin
      mix_l_p1 <= (cnt == 3'd0 ? mix_t'(0) : mix_l_p1) + (rl[1] ? mix_t'(ch) : mix_t'(0));
      mix_r_p1 <= (cnt == 3'd0 ? mix_t'(0) : mix_r_p1) + (rl[0] ? mix_t'(ch) : mix_t'(0));
    end
  end

  // Stage 2: arming, slot counter and output strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= UNARMED;
      cnt          <= 3'd0;
      vld_p1       <= 1'b0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
    end else if (clk_en) begin
      vld_p1       <= 1'b0;
      sample_valid <= vld_p1;
      if (vld_p1) begin
        left  <= mix_l_p1;
        right <= mix_r_p1;
      end
      if (s1_enters) begin
        cnt   <= 3'd0;
        state <= ARMED;
      end else if (s3_take) begin
        cnt <= cnt + 3'd1;
        if (cnt == CNT_LAST) vld_p1 <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt12_chacc.sv
// Directed bench for jt12_chacc: frames of 24 slots with hand-computed mixes.
module tb_jt12_chacc;

  logic clk = 1'b0;
  logic rst, clk_en;
  logic signed [8:0] op_result;
  logic s1_enters, s2_enters, s3_enters, s4_enters;
  logic [2:0] alg;
  logic [1:0] rl;
  logic signed [11:0] left, right;
  logic sample_valid;
`ifdef JT12_CHACC_PCM_EN
  logic signed [8:0] pcm = '0;
  logic pcm_en = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] f_alg [6];
  logic [1:0] f_rl  [6];
  logic signed [8:0] f_op [4][6];   // group index: 0=S2, 1=S4, 2=S1, 3=S3 (exit order)
  int   gap = 0;
  logic extra_s4 = 1'b0;

  always #5 clk = ~clk;

  jt12_chacc dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .op_result    (op_result),
    .s1_enters    (s1_enters),
    .s2_enters    (s2_enters),
    .s3_enters    (s3_enters),
    .s4_enters    (s4_enters),
    .alg          (alg),
    .rl           (rl),
`ifdef JT12_CHACC_PCM_EN
    .pcm          (pcm),
    .pcm_en       (pcm_en),
`endif
    .left         (left),
    .right        (right),
    .sample_valid (sample_valid)
  );

  task automatic drive(input int g, input logic signed [8:0] op, input logic [2:0] a, input logic [1:0] r);
    op_result = op; alg = a; rl = r;
    s1_enters = (g == 0);
    s3_enters = (g == 1);
    s2_enters = (g == 2);
    s4_enters = (g == 3) || (g == 0 && extra_s4);
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    s1_enters = 1'b0; s2_enters = 1'b0; s3_enters = 1'b0; s4_enters = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    drive(-1, 9'sd0, 3'd0, 2'b00);
  endtask

  task automatic run_groups(input int g0, input int g1);
    for (int g = g0; g <= g1; g++)
      for (int c = 0; c < 6; c++) drive(g, f_op[g][c], f_alg[c], f_rl[c]);
  endtask

  task automatic set_frame(input logic [2:0] a, input logic [1:0] r,
                           input logic signed [8:0] o_s2, input logic signed [8:0] o_s4,
                           input logic signed [8:0] o_s1, input logic signed [8:0] o_s3);
    for (int c = 0; c < 6; c++) begin
      f_alg[c] = a; f_rl[c] = r;
      f_op[0][c] = o_s2; f_op[1][c] = o_s4; f_op[2][c] = o_s1; f_op[3][c] = o_s3;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b0; op_result = '0; alg = '0; rl = '0;
    s1_enters = 0; s2_enters = 0; s3_enters = 0; s4_enters = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
    n_cmp++; if (left !== 12'sd0) begin n_bad++; $display("FAIL reset_left: got %0d want 0", left); end
    n_cmp++; if (right !== 12'sd0) begin n_bad++; $display("FAIL reset_right: got %0d want 0", right); end
    rst = 1'b0;
    // An S3 group before any S2 slot must not produce a sample
    set_frame(3'd7, 2'b11, 9'sd100, 9'sd100, 9'sd100, 9'sd100);
    run_groups(3, 3); idle();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL unarmed_valid: got %b want 0", sample_valid); end
    n_cmp++; if (left !== 12'sd0) begin n_bad++; $display("FAIL unarmed_left: got %0d want 0", left); end
  endtask

  task automatic test_alg7_sat();
    set_frame(3'd7, 2'b11, 9'sd100, 9'sd100, 9'sd100, 9'sd100);
    run_groups(0, 3);
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL alg7_early: got %b want 0", sample_valid); end
    idle();
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL alg7_valid: got %b want 1", sample_valid); end
    n_cmp++; if (left !== 12'sd1530) begin n_bad++; $display("FAIL alg7_left: got %0d want 1530", left); end
    n_cmp++; if (right !== 12'sd1530) begin n_bad++; $display("FAIL alg7_right: got %0d want 1530", right); end
    idle();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL alg7_pulse: got %b want 0", sample_valid); end
  endtask

  task automatic test_alg0_left();
    set_frame(3'd0, 2'b10, 9'sd200, 9'sd50, 9'sd200, 9'sd200);
    run_groups(0, 3); idle();
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL alg0_valid: got %b want 1", sample_valid); end
    n_cmp++; if (left !== 12'sd300) begin n_bad++; $display("FAIL alg0_left: got %0d want 300", left); end
    n_cmp++; if (right !== 12'sd0) begin n_bad++; $display("FAIL alg0_right: got %0d want 0", right); end
  endtask

  task automatic test_alg4_negsat();
    set_frame(3'd4, 2'b11, -9'sd200, -9'sd100, 9'sd77, 9'sd77);
    run_groups(0, 3); idle();
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL alg4_valid: got %b want 1", sample_valid); end
    n_cmp++; if (left !== -12'sd1536) begin n_bad++; $display("FAIL alg4_left: got %0d want -1536", left); end
    n_cmp++; if (right !== -12'sd1536) begin n_bad++; $display("FAIL alg4_right: got %0d want -1536", right); end
  endtask

  task automatic test_pan();
    set_frame(3'd0, 2'b00, 9'sd0, 9'sd0, 9'sd0, 9'sd0);
    for (int c = 0; c < 6; c++) begin
      f_rl[c]    = (c % 2 == 0) ? 2'b10 : 2'b01;
      f_op[1][c] = 9'(10 * (c + 1));
    end
    run_groups(0, 3); idle();
    n_cmp++; if (left !== 12'sd90) begin n_bad++; $display("FAIL pan_left: got %0d want 90", left); end
    n_cmp++; if (right !== 12'sd120) begin n_bad++; $display("FAIL pan_right: got %0d want 120", right); end
  endtask

  task automatic test_priority_and_wrap();
    set_frame(3'd5, 2'b11, 9'sd30, 9'sd40, 9'sd99, 9'sd20);
    extra_s4 = 1'b1;
    run_groups(0, 3);
    extra_s4 = 1'b0;
    idle();
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL prio_valid: got %b want 1", sample_valid); end
    n_cmp++; if (left !== 12'sd540) begin n_bad++; $display("FAIL prio_left: got %0d want 540", left); end
    idle();
    drive(3, 9'sd100, 3'd7, 2'b11);
    idle();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_valid: got %b want 0", sample_valid); end
    n_cmp++; if (left !== 12'sd540) begin n_bad++; $display("FAIL wrap_left: got %0d want 540", left); end
  endtask

  task automatic test_mid_frame_reset();
    set_frame(3'd7, 2'b11, 9'sd100, 9'sd100, 9'sd100, 9'sd100);
    run_groups(0, 1);
    for (int c = 0; c < 3; c++) drive(2, f_op[2][c], f_alg[c], f_rl[c]);
    rst = 1'b1; #3; rst = 1'b0;
    n_cmp++; if (left !== 12'sd0) begin n_bad++; $display("FAIL midrst_left_clr: got %0d want 0", left); end
    for (int c = 3; c < 6; c++) drive(2, f_op[2][c], f_alg[c], f_rl[c]);
    run_groups(3, 3); idle();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", sample_valid); end
    n_cmp++; if (right !== 12'sd0) begin n_bad++; $display("FAIL midrst_right: got %0d want 0", right); end
    set_frame(3'd0, 2'b10, 9'sd200, 9'sd50, 9'sd200, 9'sd200);
    run_groups(0, 3); idle();
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_next_valid: got %b want 1", sample_valid); end
    n_cmp++; if (left !== 12'sd300) begin n_bad++; $display("FAIL midrst_next_left: got %0d want 300", left); end
  endtask

  task automatic test_clk_en_gaps();
    set_frame(3'd0, 2'b01, 9'sd0, 9'sd0, 9'sd0, 9'sd0);
    for (int c = 0; c < 6; c++) f_op[1][c] = 9'(10 * (c + 1));
    gap = 3;
    run_groups(0, 3); idle();
    n_cmp++; if (sample_valid !== 1'b1) begin n_bad++; $display("FAIL gap_held: got %b want 1", sample_valid); end
    n_cmp++; if (right !== 12'sd210) begin n_bad++; $display("FAIL gap_right: got %0d want 210", right); end
    n_cmp++; if (left !== 12'sd0) begin n_bad++; $display("FAIL gap_left: got %0d want 0", left); end
    idle();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL gap_pulse: got %b want 0", sample_valid); end
    gap = 0;
  endtask

`ifdef JT12_CHACC_PCM_EN
  task automatic test_pcm();
    set_frame(3'd0, 2'b11, 9'sd0, 9'sd0, 9'sd0, 9'sd0);
    f_rl[5] = 2'b01; f_op[1][5] = 9'sd40;
    pcm = -9'sd77; pcm_en = 1'b1;
    run_groups(0, 3); idle();
    n_cmp++; if (right !== -12'sd77) begin n_bad++; $display("FAIL pcm_right: got %0d want -77", right); end
    n_cmp++; if (left !== 12'sd0) begin n_bad++; $display("FAIL pcm_left: got %0d want 0", left); end
    pcm_en = 1'b0;
    run_groups(0, 3); idle();
    n_cmp++; if (right !== 12'sd40) begin n_bad++; $display("FAIL pcm_off_right: got %0d want 40", right); end
  endtask
`endif

  initial begin
    test_reset();
    test_alg7_sat();
    test_alg0_left();
    test_alg4_negsat();
    test_pan();
    test_priority_and_wrap();
    test_mid_frame_reset();
    test_clk_en_gaps();
`ifdef JT12_CHACC_PCM_EN
    test_pcm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
